// File: rtl/flp_to_int_converter.sv
// IEEE-754 double to signed integer converter: 3-stage pipeline (unpack, align, round/saturate)
// with optional power-of-two scaling, round-half-even, saturation and an overflow event counter.
module flp_to_int_converter #(
  parameter int INT_BITS         = 64,
  parameter int FRAC_SHIFT       = 0,
  parameter int EXPONENT_BITS    = 11,
  parameter int SIGNIFICANT_BITS = 52,
  parameter int OVERALL_BITS     = EXPONENT_BITS + SIGNIFICANT_BITS + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [OVERALL_BITS-1:0] a,
  input  logic                    clr_count,
  output logic [INT_BITS-1:0]     result,
  output logic                    done,
  output logic                    overflow,
  output logic [15:0]             ovf_count
);

  localparam int FB    = SIGNIFICANT_BITS + 1;
  localparam int IW    = INT_BITS + 1;
  localparam int EXP_W = EXPONENT_BITS + 9;
  localparam int BIAS  = 2 ** (EXPONENT_BITS - 1) - 1;

  localparam logic signed [EXP_W-1:0] E_LIM  = EXP_W'(INT_BITS);
  localparam logic signed [EXP_W-1:0] E_NEG1 = '1;

  localparam logic [IW-1:0] POS_LIM = {2'b00, {(INT_BITS-1){1'b1}}};
  localparam logic [IW-1:0] NEG_LIM = {1'b0, 1'b1, {(INT_BITS-1){1'b0}}};
  localparam logic [INT_BITS-1:0] SAT_POS = {1'b0, {(INT_BITS-1){1'b1}}};
  localparam logic [INT_BITS-1:0] SAT_NEG = {1'b1, {(INT_BITS-1){1'b0}}};

  typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_NORM} cls_t;

  // ---------------- stage 1: unpack ----------------
  logic                       sgn_in;
  logic [EXPONENT_BITS-1:0]   exp_in;
  logic [SIGNIFICANT_BITS-1:0] frac_in;
  logic signed [EXP_W-1:0]    exp_unb;
  cls_t                       cls_in;

  assign sgn_in  = a[OVERALL_BITS-1];
  assign exp_in  = a[OVERALL_BITS-2 -: EXPONENT_BITS];
  assign frac_in = a[SIGNIFICANT_BITS-1:0];
  assign exp_unb = EXP_W'(exp_in) - EXP_W'(BIAS) + EXP_W'(FRAC_SHIFT);

  always_comb begin
    cls_in = CLS_NORM;
    if (exp_in == '0)
      cls_in = CLS_ZERO;
    else if (exp_in == '1)
      cls_in = (frac_in == '0) ? CLS_INF : CLS_NAN;
  end

  logic                    v1, s1;
  logic signed [EXP_W-1:0] e1;
  logic [FB-1:0]           m1;
  cls_t                    c1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
    end else begin
      v1 <= start;
      if (start) begin
        s1 <= sgn_in;
        e1 <= exp_unb;
        m1 <= {1'b1, frac_in};
        c1 <= cls_in;
      end
    end
  end

  // ---------------- stage 2: align ----------------
  // Left-shift m by E+1 into a fixed-point word with FB fraction bits; E is
  // limited to [-1, INT_BITS-1] on this path so the shift is never negative.
  logic [6:0]         sh;
  logic [IW+FB-1:0]   shifted;
  logic               pre_ovf, tiny;
  logic [IW-1:0]      int_n;
  logic               g_n, st_n;

  assign sh      = e1[6:0] + 7'd1;
  assign shifted = {{IW{1'b0}}, m1} << sh;
  assign pre_ovf = (e1 >= E_LIM);
  assign tiny    = (e1 < E_NEG1);

  always_comb begin
    int_n = shifted[FB +: IW];
    g_n   = shifted[FB-1];
    st_n  = |shifted[FB-2:0];
    if (tiny || pre_ovf) begin
      int_n = '0;
      g_n   = 1'b0;
      st_n  = tiny;
    end
  end

  logic          v2, s2, po2, g2, st2;
  logic [IW-1:0] int2;
  cls_t          c2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        s2   <= s1;
        po2  <= pre_ovf;
        int2 <= int_n;
        g2   <= g_n;
        st2  <= st_n;
        c2   <= c1;
      end
    end
  end

  // ---------------- stage 3: round / saturate ----------------
  logic                inc, mag_ovf;
  logic [IW-1:0]       rounded;
  logic [INT_BITS-1:0] neg, sat, res_n;
  logic                ovf_n;

  assign inc     = g2 & (st2 | int2[0]);
  assign rounded = int2 + IW'(inc);
  assign mag_ovf = s2 ? (rounded > NEG_LIM) : (rounded > POS_LIM);
  assign neg     = (~rounded[INT_BITS-1:0]) + {{(INT_BITS-1){1'b0}}, 1'b1};
  assign sat     = s2 ? SAT_NEG : SAT_POS;

  always_comb begin
    res_n = '0;
    ovf_n = 1'b0;
    unique case (c2)
      CLS_ZERO: begin
        res_n = '0;
        ovf_n = 1'b0;
      end
      CLS_INF: begin
        res_n = sat;
        ovf_n = 1'b1;
      end
      CLS_NAN: begin
        res_n = '0;
        ovf_n = 1'b1;
      end
      default: begin
        if (po2 || mag_ovf) begin
          res_n = sat;
          ovf_n = 1'b1;
        end else begin
          res_n = s2 ? neg : rounded[INT_BITS-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= v2;
      if (v2) begin
        result   <= res_n;
        overflow <= ovf_n;
      end
    end
  end

  // ---------------- overflow counter ----------------
  // Clear is applied before the increment, so a coincident event leaves 1.
  logic [15:0] cnt_base, cnt_n;

  always_comb begin
    cnt_base = clr_count ? '0 : ovf_count;
    cnt_n    = cnt_base;
    if (done && overflow && cnt_base != '1)
      cnt_n = cnt_base + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf_count <= '0;
    else
      ovf_count <= cnt_n;
  end

endmodule

// File: tb/tb_flp_to_int_converter.sv
// Scoreboard bench for flp_to_int_converter: two instances (64-bit/no scale, 32-bit/scale 4)
// driven with directed vectors; monitors pop expected results on every done pulse.
module tb_flp_to_int_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start64 = 1'b0, start32 = 1'b0, clr_count = 1'b0;
  logic [63:0] a64 = '0, a32 = '0;

  logic [63:0] res64;
  logic        done64, ovf64;
  logic [15:0] cnt64;
  logic [31:0] res32;
  logic        done32, ovf32;
  logic [15:0] cnt32;

  always #5 clk = ~clk;

  flp_to_int_converter #(.INT_BITS(64), .FRAC_SHIFT(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .a(a64), .clr_count(clr_count),
    .result(res64), .done(done64), .overflow(ovf64), .ovf_count(cnt64)
  );

  flp_to_int_converter #(.INT_BITS(32), .FRAC_SHIFT(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .clr_count(clr_count),
    .result(res32), .done(done32), .overflow(ovf32), .ovf_count(cnt32)
  );

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  exp_t q64[$];
  exp_t q32[$];
  exp_t e64, e32;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done64) begin
      if (q64.size() == 0) begin
        chk("spurious_done64", 64'd1, 64'd0);
      end else begin
        e64 = q64.pop_front();
        chk("result64", res64, e64.res);
        chk("overflow64", 64'(ovf64), 64'(e64.ovf));
        chk("latency64", 64'(cyc - e64.cyc), 64'd3);
      end
    end
    if (done32) begin
      if (q32.size() == 0) begin
        chk("spurious_done32", 64'd1, 64'd0);
      end else begin
        e32 = q32.pop_front();
        chk("result32", 64'(res32), e32.res);
        chk("overflow32", 64'(ovf32), 64'(e32.ovf));
        chk("latency32", 64'(cyc - e32.cyc), 64'd3);
      end
    end
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic issue64(input logic [63:0] v, input logic [63:0] r, input logic o);
    start64 = 1'b1;
    a64     = v;
    q64.push_back('{res: r, ovf: o, cyc: cyc});
    sync();
    start64 = 1'b0;
  endtask

  task automatic issue32(input logic [63:0] v, input logic [31:0] r, input logic o);
    start32 = 1'b1;
    a32     = v;
    q32.push_back('{res: 64'(r), ovf: o, cyc: cyc});
    sync();
    start32 = 1'b0;
  endtask

  // Waits for both scoreboards to empty, then one more cycle so ovf_count settles.
  task automatic drain;
    int n = 0;
    while ((q64.size() != 0 || q32.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(q64.size() + q32.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_res64"},  res64,          64'd0);
    chk({tag, "_done64"}, 64'(done64),    64'd0);
    chk({tag, "_ovf64"},  64'(ovf64),     64'd0);
    chk({tag, "_cnt64"},  64'(cnt64),     64'd0);
    chk({tag, "_res32"},  64'(res32),     64'd0);
    chk({tag, "_done32"}, 64'(done32),    64'd0);
    chk({tag, "_ovf32"},  64'(ovf32),     64'd0);
    chk({tag, "_cnt32"},  64'(cnt32),     64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got t=%0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");
    sync();

    // ties to even, back-to-back
    issue64(64'h3FF8000000000000, 64'd2, 1'b0);
    issue64(64'h4004000000000000, 64'd2, 1'b0);
    issue64(64'hC004000000000000, 64'hFFFFFFFFFFFFFFFE, 1'b0);
    // small magnitudes and a subnormal
    issue64(64'h3FE0000000000000, 64'd0, 1'b0);
    issue64(64'h3FE8000000000000, 64'd1, 1'b0);
    issue64(64'h0000000000000001, 64'd0, 1'b0);
    // saturation boundaries and specials
    issue64(64'h43E0000000000000, 64'h7FFFFFFFFFFFFFFF, 1'b1);
    issue64(64'hC3E0000000000000, 64'h8000000000000000, 1'b0);
    issue64(64'h7FF0000000000000, 64'h7FFFFFFFFFFFFFFF, 1'b1);
    issue64(64'h7FF8000000000000, 64'd0, 1'b1);
    drain();
    chk("ovf_count64_sat", 64'(cnt64), 64'd3);
    sync();

    // scaled 32-bit instance
    issue32(64'h3FF8000000000000, 32'd24, 1'b0);
    issue32(64'h41E0000000000000, 32'h7FFFFFFF, 1'b1);
    issue32(64'hC1A0000000000000, 32'h80000000, 1'b0);
    issue32(64'hC1B0000000000000, 32'h80000000, 1'b1);
    issue64(64'hFFF0000000000000, 64'h8000000000000000, 1'b1);
    drain();
    chk("ovf_count32", 64'(cnt32), 64'd2);
    chk("ovf_count64_ninf", 64'(cnt64), 64'd4);
    sync();

    // reset with two conversions in flight: neither may produce done
    start64 = 1'b1;
    a64     = 64'h3FF8000000000000;
    sync();
    a64     = 64'h4004000000000000;
    sync();
    start64 = 1'b0;
    rst_n   = 1'b0;
    sync();
    rst_n   = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    repeat (8) @(negedge clk);
    sync();

    // drive the counter to saturation, then one more event
    for (int i = 0; i < 65535; i++)
      issue64(64'h7FF0000000000000, 64'h7FFFFFFFFFFFFFFF, 1'b1);
    drain();
    chk("ovf_count64_full", 64'(cnt64), 64'hFFFF);
    sync();
    issue64(64'hFFF0000000000000, 64'h8000000000000000, 1'b1);
    drain();
    chk("ovf_count64_hold", 64'(cnt64), 64'hFFFF);
    sync();

    // clr_count coincident with an overflowed done pulse
    issue64(64'h7FF8000000000000, 64'd0, 1'b1);
    sync();
    sync();
    clr_count = 1'b1;
    chk("done_with_clr", 64'(done64), 64'd1);
    sync();
    clr_count = 1'b0;
    @(negedge clk);
    chk("ovf_count64_clr_inc", 64'(cnt64), 64'd1);
    chk("ovf_count32_clr", 64'(cnt32), 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
